softmax_div_arbiter: RTL



---
 rtl/softmax_div_pkg.sv | 8 +
 rtl/softmax_div_core.sv | 33 +++
 rtl/softmax_div_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/softmax_div_pkg.sv
// softmax_div_pkg: shared FSM state type and operand widths for the softmax divide arbiter
package softmax_div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} div_state_t;
    localparam int DIV_XW = 16;
    localparam int DIV_YW = 32;
    localparam int DIV_QW = 16;
    localparam logic [DIV_QW-1:0] Q_SAT = 16'hFFFF;
endpackage

// File: rtl/softmax_div_core.sv
// softmax_div_core: combinational restoring divide of {x,16'b0} by y with saturation and divide-by-zero handling
module softmax_div_core
    import softmax_div_pkg::*;
(
    input  logic [DIV_XW-1:0] i_x,
    input  logic [DIV_YW-1:0] i_y,
    output logic [DIV_QW-1:0] o_q,
    output logic [DIV_YW-1:0] o_r,
    output logic              o_sat
);
    logic [DIV_YW-1:0] w_d;
    logic [DIV_YW-1:0] w_rem;
    logic [DIV_YW-1:0] w_quo;
    logic              w_top;
    assign w_d = {i_x, {(DIV_YW-DIV_XW){1'b0}}};
    // a bit shifted out of the top means the partial remainder exceeds any 32-bit divisor
    always_comb begin
        w_rem = '0;
        w_quo = '0;
        w_top = 1'b0;
        for (int i = DIV_YW-1; i >= 0; i--) begin
            w_top = w_rem[DIV_YW-1];
            w_rem = {w_rem[DIV_YW-2:0], w_d[i]};
            if (w_top || w_rem >= i_y) begin
                w_rem    = w_rem - i_y;
                w_quo[i] = 1'b1;
            end
        end
    end
    assign o_sat = (i_y == '0) | (|w_quo[DIV_YW-1:DIV_QW]);
    assign o_q   = o_sat ? Q_SAT : w_quo[DIV_QW-1:0];
    assign o_r   = o_sat ? '0 : w_rem;
endmodule

// File: rtl/softmax_div_arbiter.sv
// softmax_div_arbiter: round-robin share of one divide core among NREQ lanes; SOFTMAX_DIV_ZERO_BYPASS_EN adds rsp_dz and a 1-cycle Y==0 path
module softmax_div_arbiter
    import softmax_div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DIV_XW-1:0] req_x,
    input  logic [NREQ*DIV_YW-1:0] req_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DIV_QW-1:0]      rsp_q,
    output logic [DIV_YW-1:0]      rsp_r,
    output logic                   rsp_sat
`ifdef SOFTMAX_DIV_ZERO_BYPASS_EN
    ,
    output logic                   rsp_dz
`endif
);
    div_state_t        r_state, w_nxt;
    logic [IDW-1:0]    r_last_g, r_id, w_gnt, w_idx;
    logic              w_any, w_byp, w_grant;
    logic [DIV_XW-1:0] w_x [NREQ];
    logic [DIV_YW-1:0] w_y [NREQ];
    logic [DIV_XW-1:0] r_x;
    logic [DIV_YW-1:0] r_y, r_r, w_r;
    logic [DIV_QW-1:0] r_q, w_q;
    logic              r_sat, w_sat;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign w_x[i] = req_x[i*DIV_XW +: DIV_XW];
        assign w_y[i] = req_y[i*DIV_YW +: DIV_YW];
    end

    // scanning from the farthest lane back lets the nearest one after last_g win
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last_g) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_gnt = w_idx;
                w_any = 1'b1;
            end
        end
    end

`ifdef SOFTMAX_DIV_ZERO_BYPASS_EN
    assign w_byp = (w_y[w_gnt] == '0);
`else
    assign w_byp = 1'b0;
`endif
    assign w_grant = (r_state == IDLE) && w_any;

    always_comb begin
        w_nxt     = r_state;
        req_ready = '0;
        case (r_state)
            IDLE: if (w_any) begin
                w_nxt            = w_byp ? RESP : CALC;
                req_ready[w_gnt] = rst_n;
            end
            CALC:    w_nxt = RESP;
            RESP:    w_nxt = rsp_ready ? IDLE : RESP;
            default: w_nxt = IDLE;
        endcase
    end

    softmax_div_core u_core (
        .i_x   (r_x),
        .i_y   (r_y),
        .o_q   (w_q),
        .o_r   (w_r),
        .o_sat (w_sat)
    );

`ifdef SOFTMAX_DIV_ZERO_BYPASS_EN
    logic r_dz;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dz <= 1'b0;
        else if (w_grant && w_byp)
            r_dz <= 1'b1;
        else if (r_state == CALC)
            r_dz <= 1'b0;
    end
    assign rsp_dz = r_dz;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last_g <= IDW'(NREQ-1);
            r_x      <= '0;
            r_y      <= '0;
            r_id     <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_grant) begin
                r_last_g <= w_gnt;
                r_x      <= w_x[w_gnt];
                r_y      <= w_y[w_gnt];
            end
            if (w_grant && w_byp) begin
                r_id  <= w_gnt;
                r_q   <= Q_SAT;
                r_r   <= '0;
                r_sat <= 1'b1;
            end else if (r_state == CALC) begin
                r_id  <= r_last_g;
                r_q   <= w_q;
                r_r   <= w_r;
                r_sat <= w_sat;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_q     = r_q;
    assign rsp_r     = r_r;
    assign rsp_sat   = r_sat;
endmodule
